// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard and stall/flush controller for a five-stage pipeline.
//
// Purpose:
//   Decides stage stalls and flushes from memory wait conditions, load-use
//   hazards, control redirects and instruction-fetch waits. Selects the EX
//   operand forwarding paths. Records the cause of each cycle and watches
//   data-memory waits with a watchdog.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt   ID-stage source registers, rt-is-source flag
//   ex_rd, ex_regwrite,
//   ex_memread                 EX-stage destination, write enable, load flag
//   mem_rd, mem_regwrite       MEM-stage destination and write enable
//   wb_rd, wb_regwrite         WB-stage destination and write enable
//   ex_branch_taken, id_jump   redirect sources
//   imem_req, imem_ok          fetch request and fetch data returned
//   dmem_req, dmem_ok          data access request and access complete
//   stall_f/d/e/m              hold the stage register (combinational)
//   flush_d/e/w                load a bubble into the stage register (comb.)
//   fwd_a, fwd_b               EX operand source: 00 RF, 01 WB, 10 MEM
//   ctrl_state                 registered cause: RUN/DWAIT/LUSTALL/IWAIT
//   dmem_timeout               sticky data-memory wait watchdog flag
//   perf_stall_cycles,
//   perf_flushes               performance counters (zero unless enabled)
//
// Configuration:
//   PIPE_CTRL_PERF_EN  when defined, the two 32-bit performance counters are
//                      implemented; otherwise both ports are tied to zero.
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        imem_req,
  input  logic        imem_ok,
  input  logic        dmem_req,
  input  logic        dmem_ok,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  ctrl_state,
  output logic        dmem_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DWAIT   = 2'b01,
    ST_LUSTALL = 2'b10,
    ST_IWAIT   = 2'b11
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic       drop_pend_r;
  logic       drop_next_s;
  logic [7:0] dwait_cnt_r;
  logic       dmem_timeout_r;

  logic dstall_s, istall_s, redirect_s, lu_s, honour_s;
  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic flush_d_s, flush_e_s, flush_w_s;

  // Forwarding select: MEM result is younger, so it wins over WB on equal rd.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    logic [1:0] sel;
    if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = 2'b10;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard condition decode.
  always_comb begin
    dstall_s   = dmem_req & ~dmem_ok;
    istall_s   = imem_req & ~imem_ok;
    redirect_s = ex_branch_taken | id_jump;
    lu_s       = ex_memread & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  end

  // Priority resolution: data wait, load-use, redirect, fetch wait.
  always_comb begin
    stall_f_s    = 1'b0;
    stall_d_s    = 1'b0;
    stall_e_s    = 1'b0;
    stall_m_s    = 1'b0;
    flush_d_s    = 1'b0;
    flush_e_s    = 1'b0;
    flush_w_s    = 1'b0;
    honour_s     = 1'b0;
    state_next_s = ST_RUN;
    if (dstall_s) begin
      stall_f_s    = 1'b1;
      stall_d_s    = 1'b1;
      stall_e_s    = 1'b1;
      stall_m_s    = 1'b1;
      flush_w_s    = 1'b1;
      state_next_s = ST_DWAIT;
    end else if (lu_s) begin
      // A simultaneous taken branch is re-evaluated once EX holds the bubble.
      stall_f_s    = 1'b1;
      stall_d_s    = 1'b1;
      flush_e_s    = 1'b1;
      state_next_s = ST_LUSTALL;
    end else if (redirect_s) begin
      flush_d_s    = 1'b1;
      flush_e_s    = ex_branch_taken;
      honour_s     = 1'b1;
      state_next_s = ST_RUN;
    end else if (istall_s) begin
      stall_f_s    = 1'b1;
      flush_d_s    = 1'b1;
      state_next_s = ST_IWAIT;
    end else begin
      state_next_s = ST_RUN;
    end
  end

  // Redirect during an outstanding fetch: the fetch in flight belongs to the
  // old path, so its returning instruction must be dropped from ID.
  always_comb begin
    if (honour_s && istall_s) begin
      drop_next_s = 1'b1;
    end else if (imem_ok) begin
      drop_next_s = 1'b0;
    end else begin
      drop_next_s = drop_pend_r;
    end
  end

  // Output drive; a pending drop forces flush_d on top of the priority result.
  always_comb begin
    stall_f      = stall_f_s;
    stall_d      = stall_d_s;
    stall_e      = stall_e_s;
    stall_m      = stall_m_s;
    flush_d      = flush_d_s | drop_pend_r;
    flush_e      = flush_e_s;
    flush_w      = flush_w_s;
    fwd_a        = fwd_sel(id_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    fwd_b        = fwd_sel(id_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    ctrl_state   = state_r;
    dmem_timeout = dmem_timeout_r;
  end

  // Cause register and pending-drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RUN;
      drop_pend_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      drop_pend_r <= drop_next_s;
    end
  end

  // Data-wait watchdog: saturating run-length counter and sticky timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwait_cnt_r    <= 8'd0;
      dmem_timeout_r <= 1'b0;
    end else if (dstall_s) begin
      if (dwait_cnt_r != 8'd255) begin
        dwait_cnt_r <= dwait_cnt_r + 8'd1;
      end
      // Flag rises on the same edge the counter reaches 255.
      if (dwait_cnt_r >= 8'd254) begin
        dmem_timeout_r <= 1'b1;
      end
    end else begin
      dwait_cnt_r <= 8'd0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (stall_f | stall_d | stall_e | stall_m) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (flush_d | flush_e) begin
        perf_flush_r <= perf_flush_r + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flushes      = perf_flush_r;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flushes      = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Stimulus is driven shortly after each rising edge; the expected response for
// that cycle is computed by a behavioural model and pushed into a queue. A
// monitor samples the DUT on each falling edge, pops and compares.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic        ex_branch_taken, id_jump, imem_req, imem_ok, dmem_req, dmem_ok;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0]  fwd_a, fwd_b, ctrl_state;
  logic        dmem_timeout;
  logic [31:0] perf_stall_cycles, perf_flushes;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
    .imem_req(imem_req), .imem_ok(imem_ok),
    .dmem_req(dmem_req), .dmem_ok(dmem_ok),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_state(ctrl_state),
    .dmem_timeout(dmem_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic [4:0] erd;
    logic       ewe, eld;
    logic [4:0] mrd;
    logic       mwe;
    logic [4:0] wrd;
    logic       wwe;
    logic       br, jmp, ireq, iok, dreq, dok;
  } stim_t;

  typedef struct packed {
    logic [3:0]  stall;   // f,d,e,m
    logic [2:0]  flush;   // d,e,w
    logic [1:0]  fa, fb, st;
    logic        to;
    logic [31:0] ps, pf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state, kept in spec terms.
  bit     m_drop;
  int     m_cause;     // 0 RUN, 1 DWAIT, 2 LUSTALL, 3 IWAIT
  int     m_run;       // consecutive data-wait cycles seen so far
  bit     m_to;
  longint m_ps, m_pf;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input stim_t s);
    if (s.mwe && s.mrd != 5'd0 && s.mrd == src) return 2'b10;
    if (s.wwe && s.wrd != 5'd0 && s.wrd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive, predict, push, advance the model.
  task automatic run_cycle(input stim_t s);
    exp_t e;
    bit dst, ist, redir, lu;
    int level;
    @(posedge clk);
    #2;
    reset = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
    ex_rd = s.erd; ex_regwrite = s.ewe; ex_memread = s.eld;
    mem_rd = s.mrd; mem_regwrite = s.mwe; wb_rd = s.wrd; wb_regwrite = s.wwe;
    ex_branch_taken = s.br; id_jump = s.jmp;
    imem_req = s.ireq; imem_ok = s.iok; dmem_req = s.dreq; dmem_ok = s.dok;
    if (s.rst) begin
      m_drop = 1'b0; m_cause = 0; m_run = 0; m_to = 1'b0; m_ps = 0; m_pf = 0;
    end
    dst   = s.dreq && !s.dok;
    ist   = s.ireq && !s.iok;
    redir = s.br || s.jmp;
    lu    = s.eld && s.erd != 5'd0 && (s.erd == s.rs || (s.uses_rt && s.erd == s.rt));
    level = dst ? 1 : lu ? 2 : redir ? 3 : ist ? 4 : 0;
    case (level)
      1:       begin e.stall = 4'b1111; e.flush = 3'b001; end
      2:       begin e.stall = 4'b1100; e.flush = 3'b010; end
      3:       begin e.stall = 4'b0000; e.flush = s.br ? 3'b110 : 3'b100; end
      4:       begin e.stall = 4'b1000; e.flush = 3'b100; end
      default: begin e.stall = 4'b0000; e.flush = 3'b000; end
    endcase
    if (m_drop) e.flush[2] = 1'b1;
    e.fa = ref_fwd(s.rs, s);
    e.fb = ref_fwd(s.rt, s);
    e.st = 2'(m_cause);
    e.to = m_to;
`ifdef PIPE_CTRL_PERF_EN
    e.ps = 32'(m_ps);
    e.pf = 32'(m_pf);
`else
    e.ps = 32'd0;
    e.pf = 32'd0;
`endif
    exp_q.push_back(e);
    if (!s.rst) begin
      m_cause = (level == 1) ? 1 : (level == 2) ? 2 : (level == 4) ? 3 : 0;
      if (level == 3 && ist) m_drop = 1'b1;
      else if (s.iok)        m_drop = 1'b0;
      m_run = dst ? m_run + 1 : 0;
      if (m_run >= 255) m_to = 1'b1;
      if (e.stall != 4'b0000) m_ps = (m_ps + 1) % 64'h1_0000_0000;
      if (e.flush[2] || e.flush[1]) m_pf = (m_pf + 1) % 64'h1_0000_0000;
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rs = 5'd1; s.rt = 5'd2;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 199) == 0);
    s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
    s.uses_rt = 1'($urandom);
    s.erd = 5'($urandom_range(0, 3)); s.ewe = 1'($urandom);
    s.eld = ($urandom_range(0, 3) == 0);
    s.mrd = 5'($urandom_range(0, 3)); s.mwe = 1'($urandom);
    s.wrd = 5'($urandom_range(0, 3)); s.wwe = 1'($urandom);
    s.br = ($urandom_range(0, 5) == 0); s.jmp = ($urandom_range(0, 7) == 0);
    s.ireq = ($urandom_range(0, 1) == 0); s.iok = ($urandom_range(0, 2) == 0);
    s.dreq = ($urandom_range(0, 3) == 0); s.dok = 1'($urandom);
    return s;
  endfunction

  // Monitor: compare the DUT against the next expected entry mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_f", stall_f, e.stall[3]);
        chk("stall_d", stall_d, e.stall[2]);
        chk("stall_e", stall_e, e.stall[1]);
        chk("stall_m", stall_m, e.stall[0]);
        chk("flush_d", flush_d, e.flush[2]);
        chk("flush_e", flush_e, e.flush[1]);
        chk("flush_w", flush_w, e.flush[0]);
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
        chk("ctrl_state", ctrl_state, e.st);
        chk("dmem_timeout", dmem_timeout, e.to);
        chk("perf_stall_cycles", perf_stall_cycles, e.ps);
        chk("perf_flushes", perf_flushes, e.pf);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rd = 5'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 5'd0; mem_regwrite = 1'b0;
    wb_rd = 5'd0; wb_regwrite = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
    imem_req = 1'b0; imem_ok = 1'b0; dmem_req = 1'b0; dmem_ok = 1'b0;
    m_drop = 1'b0; m_cause = 0; m_run = 0; m_to = 1'b0; m_ps = 0; m_pf = 0;

    s = idle(); s.rst = 1'b1;
    run_cycle(s); run_cycle(s);
    s = idle();
    run_cycle(s); run_cycle(s);

    // Load-use on rs, then LUSTALL recorded.
    s = idle(); s.eld = 1'b1; s.erd = 5'd5; s.rs = 5'd5;
    run_cycle(s);
    s = idle();
    run_cycle(s);

    // Forwarding: MEM beats WB; register 0 never forwards.
    s = idle(); s.mwe = 1'b1; s.mrd = 5'd3; s.wwe = 1'b1; s.wrd = 5'd3; s.rs = 5'd3;
    run_cycle(s);
    s = idle(); s.mwe = 1'b1; s.mrd = 5'd0; s.wwe = 1'b1; s.wrd = 5'd0; s.rs = 5'd0;
    run_cycle(s);
    s = idle(); s.wwe = 1'b1; s.wrd = 5'd7; s.rt = 5'd7;
    run_cycle(s);

    // Long data-memory wait crosses the watchdog limit; flag stays afterwards.
    s = idle(); s.dreq = 1'b1; s.br = 1'b1;
    for (int i = 0; i < 300; i++) run_cycle(s);
    s = idle(); s.dreq = 1'b1; s.dok = 1'b1;
    run_cycle(s);
    s = idle();
    for (int i = 0; i < 3; i++) run_cycle(s);

    // Branch during fetch wait: flush_d held through the imem_ok cycle.
    s = idle(); s.br = 1'b1; s.ireq = 1'b1;
    run_cycle(s);
    s = idle(); s.ireq = 1'b1;
    run_cycle(s); run_cycle(s);
    s = idle(); s.ireq = 1'b1; s.iok = 1'b1;
    run_cycle(s);
    s = idle();
    run_cycle(s); run_cycle(s);

    // Load-use wins over a taken branch.
    s = idle(); s.eld = 1'b1; s.erd = 5'd5; s.rs = 5'd5; s.br = 1'b1;
    run_cycle(s);
    s = idle(); s.br = 1'b1;
    run_cycle(s);

    // Reset pulse in the middle of a data wait.
    s = idle(); s.dreq = 1'b1;
    for (int i = 0; i < 260; i++) run_cycle(s);
    s.rst = 1'b1;
    run_cycle(s);
    s.rst = 1'b0;
    run_cycle(s); run_cycle(s);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) run_cycle(rnd());

    s = idle();
    run_cycle(s);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL be clocked by one clock with an asynchronous, active-high reset, using the port names below.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 id_rs, id_rt  in  5 each  ID-stage source registers; id_uses_rt  in  1  rt is a source (R-type, SW, BEQ).
REQ-005 ex_rd  in  5; ex_regwrite, ex_memread  in  1 each  EX-stage destination, write enable, LW flag.
REQ-006 mem_rd  in  5; mem_regwrite  in  1  MEM-stage destination and write enable.
REQ-007 wb_rd  in  5; wb_regwrite  in  1  WB-stage destination and write enable.
REQ-008 ex_branch_taken  in  1  BEQ resolved taken in EX; id_jump  in  1  J decoded in ID.
REQ-009 imem_req, imem_ok  in  1 each  fetch request valid and fetch data returned.
REQ-010 dmem_req, dmem_ok  in  1 each  MEM-stage LW/SW valid and access complete.
REQ-011 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register.
REQ-012 flush_d, flush_e, flush_w  out  1 each  load a bubble into the stage register.
REQ-013 fwd_a, fwd_b  out  2 each  operand source for rs/rt in EX: 00 register file, 01 WB, 10 MEM.
REQ-014 ctrl_state  out  2  registered cause: 00 RUN, 01 DWAIT, 10 LUSTALL, 11 IWAIT.
REQ-015 dmem_timeout  out  1  sticky data-memory wait watchdog flag.

Function
REQ-016 dstall = dmem_req & !dmem_ok; istall = imem_req & !imem_ok; redirect = ex_branch_taken | id_jump.
REQ-017 lu = ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-018 Priority 1, dstall: stall_f/d/e/m=1, flush_w=1, all other stall/flush outputs 0; redirect ignored this cycle.
REQ-019 Priority 2, lu: stall_f=stall_d=1, flush_e=1, others 0.
REQ-020 Priority 3, ex_branch_taken: flush_d=flush_e=1; id_jump alone: flush_d=1; stall outputs 0.
REQ-021 Priority 4, istall: stall_f=1, flush_d=1; others 0.
REQ-022 Otherwise all stall/flush outputs SHALL be 0.
REQ-023 Stall and flush outputs SHALL be combinational from inputs and drop_pend, zero-cycle latency.
REQ-024 drop_pend (internal, 1 bit) SHALL set when a redirect is honoured (REQ-020) while istall=1; SHALL clear on the first cycle imem_ok=1; while set, flush_d=1 is forced in addition to REQ-018..021 outputs.
REQ-025 Forwarding: fwd_x=10 when mem_regwrite & mem_rd!=0 & mem_rd==src; else 01 when wb_regwrite & wb_rd!=0 & wb_rd==src; else 00; MEM beats WB on equal rd.
REQ-026 ctrl_state SHALL register the priority level taken each cycle (DWAIT, LUSTALL, IWAIT, else RUN); redirect cycles record RUN.
REQ-027 An 8-bit dwait counter SHALL increment every dstall cycle, saturate at 255, clear on any non-dstall cycle; dmem_timeout SHALL set when it reaches 255 and stay set until reset.
REQ-028 Simultaneous lu and ex_branch_taken: lu wins; branch re-evaluated next cycle with EX holding the bubble.

Reset
REQ-029 Reset SHALL force ctrl_state=RUN, drop_pend=0, dwait counter=0, dmem_timeout=0, perf counters=0, regardless of clock.
REQ-030 During reset, combinational outputs SHALL follow REQ-016..025 using the cleared state.

Configuration
REQ-031 With PIPE_CTRL_PERF_EN defined, outputs perf_stall_cycles (32, cycles with any stall_* =1) and perf_flushes (32, cycles with flush_d or flush_e =1) SHALL exist, wrapping at 2^32.
REQ-032 Without PIPE_CTRL_PERF_EN, both ports SHALL be present and tied to 0, with no counter logic.

Verification
REQ-033 ex_memread=1, ex_rd=5, id_rs=5 -> stall_f=stall_d=flush_e=1, ctrl_state=10 next cycle.
REQ-034 mem_regwrite=1, mem_rd=3, wb_regwrite=1, wb_rd=3, id_rs=3 -> fwd_a=10; mem_rd=0 with id_rs=0 -> fwd_a=00.
REQ-035 dmem_req=1, dmem_ok=0 for 300 cycles -> stall_m=flush_w=1 throughout, dmem_timeout=1 from cycle 255, stays after dmem_ok.
REQ-036 ex_branch_taken=1 with imem_req=1, imem_ok=0 -> flush_d=flush_e=1; flush_d stays 1 until the imem_ok cycle inclusive, then 0.
REQ-037 lu and ex_branch_taken together -> only lu outputs; reset pulse mid-DWAIT -> ctrl_state=00, dmem_timeout=0 immediately.
